// File: rtl/sqrt_ctrl.sv
// Sequencing controller for a bit-serial restoring square-root datapath.
// Issues load/shift/check strobes; the datapath registers sample them on the falling edge.
module sqrt_ctrl #(
   parameter int unsigned ITER = 16,
   parameter int unsigned CW   = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          init,
   input  logic          ge,
   output logic          ld,
   output logic          sh_a,
   output logic          sh_q,
   output logic          in_bit,
   output logic          wr_r,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] iter_cnt
);

   localparam logic [CW-1:0] CNT_INIT = CW'(ITER);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_SHIFT = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_next;
   logic            r_ld;
   logic            r_sh_a;
   logic            r_sh_q;
   logic            r_busy;
   logic            r_done;

   // Next-state and iteration counter update
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (init) w_state_next = S_LOAD;
         end
         S_LOAD: begin
            w_cnt_next   = CNT_INIT;
            w_state_next = S_SHIFT;
         end
         S_SHIFT: begin
            w_state_next = S_CHECK;
         end
         S_CHECK: begin
            w_cnt_next   = r_cnt - CNT_ONE;
            w_state_next = (r_cnt == CNT_ONE) ? S_DONE : S_SHIFT;
         end
         S_DONE: begin
            if (!init) w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // State, counter and strobes registered from the next state so they settle right after the rising edge
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ld    <= 1'b0;
         r_sh_a  <= 1'b0;
         r_sh_q  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_ld    <= (w_state_next == S_LOAD);
         r_sh_a  <= (w_state_next == S_SHIFT);
         r_sh_q  <= (w_state_next == S_CHECK);
         r_busy  <= (w_state_next == S_LOAD) || (w_state_next == S_SHIFT) ||
                    (w_state_next == S_CHECK);
         r_done  <= (w_state_next == S_DONE);
      end
   end

   // ge only matters during CHECK, where it picks the result bit and remainder update
   assign in_bit   = r_sh_q & ge;
   assign wr_r     = r_sh_q & ge;
   assign ld       = r_ld;
   assign sh_a     = r_sh_a;
   assign sh_q     = r_sh_q;
   assign busy     = r_busy;
   assign done     = r_done;
   assign iter_cnt = r_cnt;

endmodule

// File: tb/tb_sqrt_ctrl.sv
// Self-checking bench for sqrt_ctrl: golden restoring-sqrt datapath, scoreboard of expected roots,
// plus directed reset, held-init and ITER=1 sequences.
module tb_sqrt_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        init;
   logic        ge;
   logic        ld, sh_a, sh_q, in_bit, wr_r, busy, done;
   logic [4:0]  iter_cnt;

   logic        init1;
   logic        ge1;
   logic        ld1, sh_a1, sh_q1, in_bit1, wr_r1, busy1, done1;
   logic [0:0]  iter_cnt1;

   always #5 clk = ~clk;

   sqrt_ctrl #(.ITER(16), .CW(5)) dut (
      .clk(clk), .reset(reset), .init(init), .ge(ge),
      .ld(ld), .sh_a(sh_a), .sh_q(sh_q), .in_bit(in_bit), .wr_r(wr_r),
      .busy(busy), .done(done), .iter_cnt(iter_cnt)
   );

   sqrt_ctrl #(.ITER(1), .CW(1)) dut1 (
      .clk(clk), .reset(reset), .init(init1), .ge(ge1),
      .ld(ld1), .sh_a(sh_a1), .sh_q(sh_q1), .in_bit(in_bit1), .wr_r(wr_r1),
      .busy(busy1), .done(done1), .iter_cnt(iter_cnt1)
   );

   // Golden datapath: radicand, remainder and result registers clocked on the falling edge
   logic [1:0]         mode;      // 0 golden ge, 1 ge=1, 2 ge=0
   logic [31:0]        rad_in;
   logic [31:0]        m_rad;
   logic signed [35:0] m_rem;
   logic [15:0]        m_q;
   logic signed [35:0] m_trial;

   assign m_trial = m_rem - $signed({18'd0, m_q, 2'b01});
   assign ge = (mode == 2'd0) ? ~m_trial[35] : (mode == 2'd1);

   always @(negedge clk) begin
      if (ld) begin
         m_rad <= rad_in;
         m_rem <= '0;
         m_q   <= '0;
      end else if (sh_a) begin
         m_rem <= {m_rem[33:0], m_rad[31:30]};
         m_rad <= m_rad << 2;
      end else if (sh_q) begin
         m_q <= {m_q[14:0], in_bit};
         if (wr_r) m_rem <= m_trial;
      end
   end

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] rad;
      logic [15:0] exp_q;
   } vec_t;

   typedef struct {
      int          lat;
      logic [15:0] q;
      int          shq;
      int          sha;
      int          wr;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[6];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full root on the ITER=16 instance; expectations go to the scoreboard when init is driven
   task automatic run_root(input vec_t v, input bit rand_init);
      exp_t        e;
      exp_t        got;
      logic [15:0] stream;
      int          c, n_sha, n_shq, n_wr, viol;
      bit          pend;
      mode   = v.mode;
      rad_in = v.rad;
      e.lat = 34; e.q = v.exp_q; e.shq = 16; e.sha = 16; e.wr = $countones(v.exp_q);
      sb_q.push_back(e);
      init = 1'b1;
      tick();
      init = 1'b0;
      stream = '0; n_sha = 0; n_shq = 0; n_wr = 0; viol = 0; pend = 1'b0;
      c = 1;
      chk("first_ld", 32'(ld), 32'd1);
      while (c <= 60) begin
         if ($countones({ld, sh_a, sh_q}) > 1) viol++;
         if ((wr_r || in_bit) && !sh_q) viol++;
         if (busy && done) viol++;
         if (sh_a) begin
            if (pend) viol++;
            if (n_sha == 0) chk("cnt_after_load", 32'(iter_cnt), 32'd16);
            pend = 1'b1;
            n_sha++;
         end
         if (sh_q) begin
            if (!pend) viol++;
            pend = 1'b0;
            n_shq++;
            stream = {stream[14:0], in_bit};
            if (wr_r) n_wr++;
         end
         if (done) break;
         init = rand_init ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
         c++;
      end
      init = 1'b0;
      chk("done_reached", 32'(done), 32'd1);
      got.lat = c; got.q = stream; got.shq = n_shq; got.sha = n_sha; got.wr = n_wr;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk("latency", 32'(got.lat), 32'(e.lat));
         chk("result_stream", 32'(got.q), 32'(e.q));
         chk("sh_q_count", 32'(got.shq), 32'(e.shq));
         chk("sh_a_count", 32'(got.sha), 32'(e.sha));
         chk("wr_r_count", 32'(got.wr), 32'(e.wr));
      end
      chk("strobe_rules", 32'(viol), 32'd0);
      chk("cnt_in_done", 32'(iter_cnt), 32'd0);
      tick();
      chk("back_to_idle", 32'({busy, done, ld}), 32'd0);
   endtask

   initial begin
      int   n, hv, k;
      logic [3:0] trace [4];

      vecs[0] = '{mode: 2'd0, rad: 32'd1000000,   exp_q: 16'd1000};
      vecs[1] = '{mode: 2'd0, rad: 32'd0,         exp_q: 16'd0};
      vecs[2] = '{mode: 2'd0, rad: 32'hFFFF_FFFF, exp_q: 16'hFFFF};
      vecs[3] = '{mode: 2'd0, rad: 32'd99,        exp_q: 16'd9};
      vecs[4] = '{mode: 2'd1, rad: 32'd12345,     exp_q: 16'hFFFF};
      vecs[5] = '{mode: 2'd2, rad: 32'd12345,     exp_q: 16'h0000};

      // Reset held with init high, then released with init still high
      mode = 2'd1; rad_in = '0; ge1 = 1'b1; init1 = 1'b0;
      reset = 1'b0; init = 1'b1;
      tick();
      tick();
      chk("rst_outputs", 32'({ld, sh_a, sh_q, in_bit, wr_r, busy, done}), 32'd0);
      chk("rst_iter_cnt", 32'(iter_cnt), 32'd0);
      chk("rst_outputs_iter1", 32'({ld1, sh_a1, sh_q1, busy1, done1, iter_cnt1}), 32'd0);
      reset = 1'b1;
      tick();
      chk("rst_release_ld", 32'(ld), 32'd1);
      reset = 1'b0; init = 1'b0;
      tick();
      chk("rst_abort_load", 32'({ld, busy, iter_cnt}), 32'd0);
      reset = 1'b1;
      tick();
      chk("idle_waits_init", 32'({ld, busy}), 32'd0);

      foreach (vecs[i]) run_root(vecs[i], 1'b1);

      // init held through DONE must not restart
      mode = 2'd0; rad_in = 32'd1000000;
      init = 1'b1;
      tick();
      k = 1;
      while (!done && k < 60) begin tick(); k++; end
      chk("hold_done_reached", 32'(k), 32'd34);
      hv = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!done || ld || busy) hv++;
      end
      chk("hold_done_stable", 32'(hv), 32'd0);
      init = 1'b0;
      tick();
      chk("hold_release_idle", 32'({busy, done}), 32'd0);
      init = 1'b1;
      tick();
      chk("hold_restart_ld", 32'(ld), 32'd1);
      init = 1'b0;
      k = 0;
      while (!done && k < 60) begin tick(); k++; end
      chk("hold_drain_done", 32'(done), 32'd1);
      tick();

      // Reset during the 5th CHECK, then a clean full root
      init = 1'b1;
      tick();
      init = 1'b0;
      n = 0; k = 0;
      while (k < 60) begin
         if (sh_q) n++;
         if (n == 5) break;
         tick();
         k++;
      end
      chk("mid_fifth_check", 32'(n), 32'd5);
      reset = 1'b0;
      tick();
      chk("mid_rst_outputs", 32'({ld, sh_a, sh_q, in_bit, wr_r, busy, done}), 32'd0);
      chk("mid_rst_cnt", 32'(iter_cnt), 32'd0);
      reset = 1'b1;
      tick();
      run_root(vecs[0], 1'b0);

      // ITER=1 instance: LOAD, SHIFT, CHECK, DONE
      init1 = 1'b1;
      tick();
      init1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         trace[i] = {ld1, sh_a1, sh_q1, done1};
         if (i == 2) chk("iter1_in_bit", 32'({in_bit1, wr_r1}), 32'd3);
         if (i < 3) tick();
      end
      chk("iter1_load",  32'(trace[0]), 32'b1000);
      chk("iter1_shift", 32'(trace[1]), 32'b0100);
      chk("iter1_check", 32'(trace[2]), 32'b0010);
      chk("iter1_done",  32'(trace[3]), 32'b0001);
      tick();
      chk("iter1_idle", 32'({busy1, done1}), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
